// File: rtl/aklc_time_entry_pkg.sv
// Shared definitions for keypad time entry: FSM encoding, BCD digit
// bounds and the default entry timeout. The clock counter and alarm
// logic import the same bounds so every block agrees on a legal time.
package aklc_time_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Entered time, oldest digit in the most significant field.
  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } bcd_time_t;

  localparam logic [3:0] MAX_MS_HR      = 4'd2;  // tens of hours
  localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;  // units of hours when tens == 2
  localparam logic [3:0] MAX_MS_MIN     = 4'd5;  // tens of minutes
  localparam logic [3:0] MAX_DIGIT      = 4'd9;  // any BCD digit

  localparam int TIMEOUT_SEC_DEF = 10;

  localparam logic [2:0] MAX_DIGIT_CNT = 3'd4;

  // True for keypad codes that are decimal digits.
  function automatic logic is_digit(input logic [3:0] k);
    return k <= MAX_DIGIT;
  endfunction

endpackage

// File: rtl/aklc_time_entry_if.sv
// Keypad strobes in, entered time and status out.
interface aklc_time_entry_if;
  import aklc_time_entry_pkg::*;

  logic       one_second;
  logic [3:0] key;
  logic       key_valid;
  logic       time_button;
  logic       cancel;

  logic [3:0] new_current_time_ms_hr;
  logic [3:0] new_current_time_ls_hr;
  logic [3:0] new_current_time_ms_min;
  logic [3:0] new_current_time_ls_min;
  logic       load_new_c;
  logic       entry_active;
  logic       entry_error;

  // Entry block side.
  modport slave (
    input  one_second, key, key_valid, time_button, cancel,
    output new_current_time_ms_hr, new_current_time_ls_hr,
           new_current_time_ms_min, new_current_time_ls_min,
           load_new_c, entry_active, entry_error
  );

  // Keypad / controller side.
  modport master (
    output one_second, key, key_valid, time_button, cancel,
    input  new_current_time_ms_hr, new_current_time_ls_hr,
           new_current_time_ms_min, new_current_time_ls_min,
           load_new_c, entry_active, entry_error
  );

endinterface

// File: rtl/aklc_time_entry_time_valid.sv
// Combinational check that a BCD hh:mm is a legal 24-hour time.
// Kept standalone so alarm-time entry can reuse it.
module aklc_time_entry_time_valid
  import aklc_time_entry_pkg::*;
(
  input  bcd_time_t t_in,
  output logic      valid
);

  // 00:00 .. 23:59; hour units limited only when the tens digit is 2.
  always_comb begin
    valid = (t_in.ms_hr  <= MAX_MS_HR) &&
            (t_in.ls_hr  <= MAX_DIGIT) &&
            ((t_in.ms_hr != MAX_MS_HR) || (t_in.ls_hr <= MAX_LS_HR_AT_2)) &&
            (t_in.ms_min <= MAX_MS_MIN) &&
            (t_in.ls_min <= MAX_DIGIT);
  end

endmodule

// File: rtl/aklc_time_entry.sv
// Keypad time entry: shifts digits in, validates on time_button and
// emits a one-cycle load strobe to the clock counter. An idle keypad
// abandons the entry after TIMEOUT_SEC seconds.
module aklc_time_entry
  import aklc_time_entry_pkg::*;
#(
  parameter int TIMEOUT_SEC = TIMEOUT_SEC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  aklc_time_entry_if.slave   ifc
);

  localparam int             TW       = $clog2(TIMEOUT_SEC + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_SEC - 1);

  state_t          state;
  bcd_time_t       digits;
  logic [2:0]      cnt;
  logic [TW-1:0]   timer;
  logic            load_r;
  logic            active_r;
  logic            error_r;
  logic            time_ok;
  logic            key_dig;

  assign key_dig = ifc.key_valid && is_digit(ifc.key);

  aklc_time_entry_time_valid u_valid (
    .t_in  (digits),
    .valid (time_ok)
  );

  // Entry FSM; status outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      digits   <= '0;
      cnt      <= '0;
      timer    <= '0;
      load_r   <= 1'b0;
      active_r <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      load_r  <= 1'b0;
      error_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          // time_button and cancel have nothing to act on here.
          if (key_dig) begin
            digits   <= {12'h000, ifc.key};
            cnt      <= 3'd1;
            timer    <= '0;
            state    <= ST_ENTRY;
            active_r <= 1'b1;
          end
        end
        ST_ENTRY: begin
          if (ifc.cancel) begin
            digits   <= '0;
            cnt      <= '0;
            timer    <= '0;
            state    <= ST_IDLE;
            active_r <= 1'b0;
          end else if (ifc.time_button && cnt != 3'd0) begin
            timer    <= '0;
            active_r <= 1'b0;
            if (time_ok) begin
              // digits stay put through LOAD and into IDLE
              state  <= ST_LOAD;
              load_r <= 1'b1;
            end else begin
              digits  <= '0;
              cnt     <= '0;
              state   <= ST_IDLE;
              error_r <= 1'b1;
            end
          end else if (key_dig) begin
            // a digit beats a timeout expiring in the same cycle
            digits <= {digits.ls_hr, digits.ms_min, digits.ls_min, ifc.key};
            cnt    <= (cnt == MAX_DIGIT_CNT) ? cnt : cnt + 3'd1;
            timer  <= '0;
          end else if (ifc.one_second) begin
            if (timer == TMO_LAST) begin
              digits   <= '0;
              cnt      <= '0;
              timer    <= '0;
              state    <= ST_IDLE;
              active_r <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        ST_LOAD: begin
          // single strobe cycle; anything arriving now is dropped
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  assign ifc.new_current_time_ms_hr  = digits.ms_hr;
  assign ifc.new_current_time_ls_hr  = digits.ls_hr;
  assign ifc.new_current_time_ms_min = digits.ms_min;
  assign ifc.new_current_time_ls_min = digits.ls_min;
  assign ifc.load_new_c              = load_r;
  assign ifc.entry_active            = active_r;
  assign ifc.entry_error             = error_r;

endmodule
